// File: rtl/fire_pkg.sv
// fire_pkg: shared types and helpers for the fire expand engine.
//   TERMS / ACC_W : term count and accumulator width at the default
//                   configuration (modules derive their own from parameters).
//   fe_state_t    : engine control state.
//   requant()     : ReLU + requantisation of a lane sum to an output word.
// Build option: define FIRE_EXPAND_SAT_EN to saturate positive overflow
// instead of discarding the bits above the output slice.
package fire_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int CHIN_DEF       = 32;
    localparam int KERNEL_DIM_DEF = 3;
    localparam int TERMS          = KERNEL_DIM_DEF * KERNEL_DIM_DEF * CHIN_DEF;
    localparam int ACC_W          = 2 * WIDTH_DEF;

    // Widest word the requant helper supports; sums are passed sign-extended
    // to 2*MAX_W so one function serves every WIDTH up to MAX_W.
    localparam int MAX_W = 32;
    localparam logic [2*MAX_W-1:0] WIDE_ONE = {{(2*MAX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fe_state_t;

    // Negative sums clamp to zero. Otherwise the result is {0, sum[frac+width-2:frac]};
    // bits above that slice are either dropped or force the positive maximum.
    function automatic logic [MAX_W-1:0] requant(input logic signed [2*MAX_W-1:0] sum,
                                                 input int width,
                                                 input int frac);
        logic [2*MAX_W-1:0] shifted;
        logic [2*MAX_W-1:0] mask;
        logic [MAX_W-1:0]   res;
        mask    = (WIDE_ONE << (width - 1)) - WIDE_ONE;
        shifted = sum >> frac;
        res     = '0;
        if (!sum[2*MAX_W-1]) begin
`ifdef FIRE_EXPAND_SAT_EN
            if ((shifted >> (width - 1)) != '0) begin
                res = mask[MAX_W-1:0];
            end else begin
                res = shifted[MAX_W-1:0] & mask[MAX_W-1:0];
            end
`else
            res = shifted[MAX_W-1:0] & mask[MAX_W-1:0];
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/fire_expand_engine_if.sv
// fire_expand_engine_if: data-path bundle of the expand engine.
//   ifm_i/ifm_valid/ifm_ready : input feature-map stream (one word per beat)
//   weight_addr/weight_i      : combinational weight ROM lookup, all lanes
//   bias_i                    : per-lane biases of the latched layer
//   ofm_o/ofm_valid           : requantised output pixel, all lanes
// master = stream source / memory side, slave = engine.
interface fire_expand_engine_if #(
    parameter int WIDTH      = 16,
    parameter int DSP_NO     = 128,
    parameter int KERNEL_DIM = 3,
    parameter int CHIN       = 32
);
    localparam int TERMS_N = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int AW      = (TERMS_N > 1) ? $clog2(TERMS_N) : 1;

    logic [WIDTH-1:0]          ifm_i;
    logic                      ifm_valid;
    logic                      ifm_ready;
    logic [AW-1:0]             weight_addr;
    logic [DSP_NO*WIDTH-1:0]   weight_i;
    logic [DSP_NO*2*WIDTH-1:0] bias_i;
    logic [DSP_NO*WIDTH-1:0]   ofm_o;
    logic                      ofm_valid;

    modport master (
        output ifm_i, ifm_valid, weight_i, bias_i,
        input  ifm_ready, weight_addr, ofm_o, ofm_valid
    );

    modport slave (
        input  ifm_i, ifm_valid, weight_i, bias_i,
        output ifm_ready, weight_addr, ofm_o, ofm_valid
    );
endinterface

// File: rtl/fire_mac_lane.sv
// fire_mac_lane: one output channel of the expand engine.
//   clk, rst       : clock, synchronous active-high reset
//   beat           : accepted input beat this cycle
//   first, last    : beat is term 0 / final term of its pixel
//   ifm, weight    : operand pair for this beat
//   bias           : channel bias (2*WIDTH)
//   ofm, ofm_valid : requantised result and its one-cycle strobe
// Requant behaviour depends on FIRE_EXPAND_SAT_EN (see fire_pkg::requant).
module fire_mac_lane
    import fire_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      beat,
    input  logic                      first,
    input  logic                      last,
    input  logic signed [WIDTH-1:0]   ifm,
    input  logic signed [WIDTH-1:0]   weight,
    input  logic signed [2*WIDTH-1:0] bias,
    output logic        [WIDTH-1:0]   ofm,
    output logic                      ofm_valid
);
    localparam int LACC_W = 2 * WIDTH;

    logic signed [WIDTH-1:0]  ifm_p0_d, ifm_p0_q;
    logic signed [WIDTH-1:0]  w_p0_d, w_p0_q;
    logic                     vld_p0_d, vld_p0_q;
    logic                     first_p0_d, first_p0_q;
    logic                     last_p0_d, last_p0_q;
    logic signed [LACC_W-1:0] prod;
    logic signed [LACC_W-1:0] acc_d, acc_q;
    logic                     vld_p1_d, vld_p1_q;
    logic signed [LACC_W-1:0] sum;
    logic        [MAX_W-1:0]  rq;
    logic        [WIDTH-1:0]  ofm_d, ofm_q;
    logic                     ofm_valid_d, ofm_valid_q;

    always_comb begin
        // stage p0: operand capture on accepted beats only
        ifm_p0_d   = ifm_p0_q;
        w_p0_d     = w_p0_q;
        first_p0_d = first_p0_q;
        last_p0_d  = last_p0_q;
        vld_p0_d   = beat;
        if (beat) begin
            ifm_p0_d   = ifm;
            w_p0_d     = weight;
            first_p0_d = first;
            last_p0_d  = last;
        end

        // stage p1: multiply-accumulate; term 0 overwrites so pixels need no clear cycle
        prod     = LACC_W'(ifm_p0_q) * LACC_W'(w_p0_q);
        acc_d    = acc_q;
        if (vld_p0_q) begin
            acc_d = first_p0_q ? prod : acc_q + prod;
        end
        vld_p1_d = vld_p0_q && last_p0_q;

        // stage p2: bias, ReLU, requant of the completed pixel
        sum         = acc_q + bias;
        rq          = requant((2*MAX_W)'(sum), WIDTH, FRAC);
        ofm_d       = ofm_q;
        ofm_valid_d = vld_p1_q;
        if (vld_p1_q) begin
            ofm_d = rq[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifm_p0_q    <= '0;
            w_p0_q      <= '0;
            vld_p0_q    <= 1'b0;
            first_p0_q  <= 1'b0;
            last_p0_q   <= 1'b0;
            acc_q       <= '0;
            vld_p1_q    <= 1'b0;
            ofm_q       <= '0;
            ofm_valid_q <= 1'b0;
        end else begin
            ifm_p0_q    <= ifm_p0_d;
            w_p0_q      <= w_p0_d;
            vld_p0_q    <= vld_p0_d;
            first_p0_q  <= first_p0_d;
            last_p0_q   <= last_p0_d;
            acc_q       <= acc_d;
            vld_p1_q    <= vld_p1_d;
            ofm_q       <= ofm_d;
            ofm_valid_q <= ofm_valid_d;
        end
    end

    assign ofm       = ofm_q;
    assign ofm_valid = ofm_valid_q;

endmodule

// File: rtl/fire_expand_engine.sv
// fire_expand_engine: time-shared 3x3/1x1 expand convolution for fire layers.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a layer (IDLE only); layer_sel captured into cur_layer
//   done       : layer complete, held until done_ack
//   busy       : engine not IDLE
//   bus        : fire_expand_engine_if.slave (ifm stream, weight ROM, bias, ofm)
// Each accepted ifm word is broadcast to DSP_NO MAC lanes; a pixel spans
// KERNEL_DIM^2*CHIN beats, a layer WOUT^2 pixels.
// Build option: FIRE_EXPAND_SAT_EN selects saturating requantisation.
module fire_expand_engine
    import fire_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DSP_NO     = 128,
    parameter int CHIN       = 32,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 32,
    parameter int NUM_LAYERS = 2,
    parameter int FRAC       = 14,
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] layer_sel,
    input  logic          done_ack,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] cur_layer,
    fire_expand_engine_if.slave bus
);
    localparam int TERMS_N = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int TW      = (TERMS_N > 1) ? $clog2(TERMS_N) : 1;
    localparam int PIX     = WOUT * WOUT;
    localparam int PW      = (PIX > 1) ? $clog2(PIX) : 1;

    fe_state_t     state_d, state_q;
    logic [TW-1:0] term_cnt_d, term_cnt_q;
    logic [PW-1:0] pix_cnt_d, pix_cnt_q;
    logic [PW-1:0] out_cnt_d, out_cnt_q;
    logic [LW-1:0] cur_layer_d, cur_layer_q;
    logic          accept;
    logic          term_first;
    logic          term_last;
    logic          ofm_valid_all;

    logic [WIDTH-1:0] lane_ofm [DSP_NO];
    logic [DSP_NO-1:0] lane_vld;

    assign accept     = bus.ifm_valid && (state_q == RUN);
    assign term_first = (term_cnt_q == '0);
    assign term_last  = (term_cnt_q == TW'(TERMS_N - 1));
    // Lanes share identical control, so their strobes always agree.
    assign ofm_valid_all = &lane_vld;

    always_comb begin
        state_d     = state_q;
        term_cnt_d  = term_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        out_cnt_d   = out_cnt_q;
        cur_layer_d = cur_layer_q;

        // Earlier pixels can still strobe while DRAIN waits for the last one,
        // so completion is tracked by counting strobes.
        if (ofm_valid_all) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    term_cnt_d  = '0;
                    pix_cnt_d   = '0;
                    out_cnt_d   = '0;
                    cur_layer_d = layer_sel;
                end
            end
            RUN: begin
                if (accept) begin
                    if (term_last) begin
                        term_cnt_d = '0;
                        if (pix_cnt_q == PW'(PIX - 1)) begin
                            pix_cnt_d = '0;
                            state_d   = DRAIN;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end else begin
                        term_cnt_d = term_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ofm_valid_all && (out_cnt_q == PW'(PIX - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // start in the same cycle as done_ack is deliberately dropped
                if (done_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            term_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            cur_layer_q <= '0;
        end else begin
            state_q     <= state_d;
            term_cnt_q  <= term_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            out_cnt_q   <= out_cnt_d;
            cur_layer_q <= cur_layer_d;
        end
    end

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        fire_mac_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .beat      (accept),
            .first     (term_first),
            .last      (term_last),
            .ifm       (bus.ifm_i),
            .weight    (bus.weight_i[i*WIDTH +: WIDTH]),
            .bias      (bus.bias_i[i*2*WIDTH +: 2*WIDTH]),
            .ofm       (lane_ofm[i]),
            .ofm_valid (lane_vld[i])
        );
    end

    always_comb begin
        bus.ofm_o = '0;
        for (int i = 0; i < DSP_NO; i++) begin
            bus.ofm_o[i*WIDTH +: WIDTH] = lane_ofm[i];
        end
    end

    assign bus.ofm_valid   = ofm_valid_all;
    assign bus.ifm_ready   = (state_q == RUN);
    assign bus.weight_addr = term_cnt_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign cur_layer       = cur_layer_q;

endmodule

// File: tb/tb_fire_expand_engine.sv
// tb_fire_expand_engine: directed bench for fire_expand_engine at a reduced
// configuration (1x1 kernel, 2 input channels, 2x2 output, 2 lanes).
// Two layers live in a small weight/bias ROM indexed by cur_layer.
module tb_fire_expand_engine;
    localparam int W  = 16;
    localparam int DSP = 2;
    localparam int CH = 2;
    localparam int KD = 1;
    localparam int WO = 2;
    localparam int NL = 2;
    localparam int FR = 14;

`ifdef FIRE_EXPAND_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] OVF_EXP = 16'h4000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [0:0] layer_sel;
    logic       done_ack;
    logic       busy;
    logic       done;
    logic [0:0] cur_layer;

    fire_expand_engine_if #(.WIDTH(W), .DSP_NO(DSP), .KERNEL_DIM(KD), .CHIN(CH)) bus ();

    fire_expand_engine #(
        .WIDTH(W), .DSP_NO(DSP), .CHIN(CH), .KERNEL_DIM(KD),
        .WOUT(WO), .NUM_LAYERS(NL), .FRAC(FR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer_sel (layer_sel),
        .done_ack  (done_ack),
        .busy      (busy),
        .done      (done),
        .cur_layer (cur_layer),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // ROM model: [layer][lane][addr] weights, [layer][lane] biases
    logic [15:0] wrom [0:1][0:1][0:1];
    logic [31:0] brom [0:1][0:1];

    always_comb begin
        bus.weight_i = {wrom[cur_layer][1][bus.weight_addr], wrom[cur_layer][0][bus.weight_addr]};
        bus.bias_i   = {brom[cur_layer][1], brom[cur_layer][0]};
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // per-run stimulus and expectations
    logic [15:0] beats [0:7];
    logic [15:0] e0 [0:3];
    logic [15:0] e1 [0:3];
    int          eoff [0:3];
    int          edone;
    int          stall_at;
    int          stall_len;
    bit          poke_start;

    // t counts negedges after the one where start is raised.
    task automatic run_layer(input logic [0:0] lsel, input string nm);
        int idx;
        int k;
        int stalled;
        bit fin;
        idx = 0; k = 0; stalled = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; layer_sel = lsel; bus.ifm_valid = 1'b0;
        for (int t = 1; t <= 60 && !fin; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_start && t == 3) begin
                start = 1'b1;
                layer_sel = ~lsel;
            end
            if (bus.ofm_valid) begin
                if (k < 4) begin
                    check_vec({nm, "_lane0"}, {16'h0, bus.ofm_o[15:0]}, {16'h0, e0[k]});
                    check_vec({nm, "_lane1"}, {16'h0, bus.ofm_o[31:16]}, {16'h0, e1[k]});
                    check_vec({nm, "_strobe_t"}, t, eoff[k]);
                end
                k++;
            end
            if (t == edone - 3) check_vec({nm, "_ready_fall"}, {31'h0, bus.ifm_ready}, 32'h0);
            if (done) begin
                check_vec({nm, "_done_t"}, t, edone);
                fin = 1'b1;
            end
            bus.ifm_valid = 1'b0;
            if (idx == stall_at && stalled < stall_len) begin
                stalled++;
            end else if (idx < 8) begin
                bus.ifm_valid = 1'b1;
                bus.ifm_i     = beats[idx];
                if (bus.ifm_ready) idx++;
            end
        end
        bus.ifm_valid = 1'b0;
        start = 1'b0;
        check_vec({nm, "_strobes"}, k, 4);
        if (!fin) check_vec({nm, "_timeout"}, 32'h0, 32'h1);
    endtask

    // holds done for 10 cycles, then acks (optionally with a start that must be dropped)
    task automatic finish_layer(input string nm, input bit with_start);
        repeat (10) @(negedge clk);
        check_vec({nm, "_done_held"}, {31'h0, done}, 32'h1);
        check_vec({nm, "_busy_held"}, {31'h0, busy}, 32'h1);
        done_ack = 1'b1;
        start    = with_start;
        layer_sel = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        start    = 1'b0;
        check_vec({nm, "_ack_done"}, {31'h0, done}, 32'h0);
        check_vec({nm, "_ack_busy"}, {31'h0, busy}, 32'h0);
        @(negedge clk);
        check_vec({nm, "_idle_stays"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrom = '{'{'{16'h4000, 16'h4000}, '{16'h4000, 16'h4000}},
                 '{'{16'h4000, 16'hC000}, '{16'h0000, 16'h0000}}};
        brom = '{'{32'h0, 32'h0}, '{32'h0, 32'h1000_0000}};
        rst = 1'b1; start = 1'b0; layer_sel = 1'b0; done_ack = 1'b0;
        bus.ifm_valid = 1'b0; bus.ifm_i = '0;
        poke_start = 1'b0; stall_at = -1; stall_len = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_vec("rst_ofm_o",     bus.ofm_o, 32'h0);
        check_vec("rst_ofm_valid", {31'h0, bus.ofm_valid}, 32'h0);
        check_vec("rst_busy",      {31'h0, busy}, 32'h0);
        check_vec("rst_done",      {31'h0, done}, 32'h0);
        check_vec("rst_ready",     {31'h0, bus.ifm_ready}, 32'h0);
        check_vec("rst_cur_layer", {31'h0, cur_layer}, 32'h0);

        // Run A: layer 0, {1.0, 0.5} x {1.0, 1.0} = 1.5 -> 0x6000; ignored start mid-run
        for (int p = 0; p < 4; p++) begin
            beats[2*p] = 16'h4000; beats[2*p+1] = 16'h2000;
            e0[p] = 16'h6000; e1[p] = 16'h6000;
            eoff[p] = 2*p + 5;
        end
        edone = 12; poke_start = 1'b1; stall_at = -1;
        run_layer(1'b0, "basic");
        poke_start = 1'b0;
        check_vec("basic_layer_kept", {31'h0, cur_layer}, 32'h0);
        finish_layer("basic", 1'b0);

        // Run B: back-to-back layer 0, overflow pixel and a 5-cycle stall inside pixel 1
        beats = '{16'h4000, 16'h2000, 16'h6000, 16'h6000, 16'h2000, 16'h2000, 16'hE000, 16'h4000};
        e0 = '{16'h6000, OVF_EXP, 16'h4000, 16'h2000};
        e1 = '{16'h6000, OVF_EXP, 16'h4000, 16'h2000};
        eoff = '{5, 12, 14, 16};
        edone = 17; stall_at = 3; stall_len = 5;
        run_layer(1'b0, "stall");
        stall_at = -1; stall_len = 0;
        finish_layer("stall", 1'b1);

        // Reset during pixel 2 of a layer-1 run
        beats = '{16'h1000, 16'h2000, 16'h4000, 16'h0000, 16'h6000, 16'h6000, 16'h2000, 16'h6000};
        @(negedge clk);
        start = 1'b1; layer_sel = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            bus.ifm_valid = 1'b1;
            bus.ifm_i = beats[t-1];
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.ifm_valid = 1'b0;
        check_vec("mrst_ofm_o",     bus.ofm_o, 32'h0);
        check_vec("mrst_ofm_valid", {31'h0, bus.ofm_valid}, 32'h0);
        check_vec("mrst_busy",      {31'h0, busy}, 32'h0);
        check_vec("mrst_done",      {31'h0, done}, 32'h0);
        check_vec("mrst_ready",     {31'h0, bus.ifm_ready}, 32'h0);
        check_vec("mrst_cur_layer", {31'h0, cur_layer}, 32'h0);

        // Run C: fresh layer 1; lane 0 weights {1,-1}, lane 1 bias only (0x1000_0000 -> 0x4000)
        e0 = '{16'h0000, 16'h4000, 16'h0000, 16'h0000};
        e1 = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        eoff = '{5, 7, 9, 11};
        edone = 12;
        run_layer(1'b1, "layer1");
        check_vec("layer1_cur_layer", {31'h0, cur_layer}, 32'h1);
        finish_layer("layer1", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
